// File: rtl/heap_pkg.sv
// Shared definitions for the heap arbiter: action codes, the bad-action error word
// and the FSM state type.
package heap_pkg;

    localparam logic [7:0] ACT_FIRST = 8'd1;
    localparam logic [7:0] ACT_LAST  = 8'd30;
    localparam logic [7:0] ACT_LONG1 = 8'd12;
    localparam logic [7:0] ACT_LONG2 = 8'd13;

    localparam logic [31:0] HEAP_ERR_BAD_ACTION = 32'h1000_0280;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE
    } heap_arb_state_t;

    // A Long2 is only meaningful as the second half of a locked pair.
    function automatic logic action_legal(input logic [7:0] action, input logic locked);
        return (action >= ACT_FIRST) && (action <= ACT_LAST) &&
               !((action == ACT_LONG2) && !locked);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first eligible requester at or after
// ptr, searching upward with wrap-around.
module rr_pick #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [N-1:0] elig;
    logic [PW:0]  idx;
    logic         found;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elig
            assign elig[gi] = valid[gi] & mask[gi];
        end
    endgenerate

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && elig[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign any = |elig;

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing one Memory heap between REQUESTERS clients; drives the
// heap bus and its edge-sensitive strobe, and keeps Long1/Long2 pairs atomic.
module heap_arbiter
    import heap_pkg::*;
#(
    parameter int REQUESTERS   = 4,
    parameter int ADDRESS_BITS = 2,
    parameter int INDEX_BITS   = 1,
    parameter int DATA_BITS    = 12
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [REQUESTERS-1:0]              req_valid,
    output logic [REQUESTERS-1:0]              req_ready,
    input  logic [8*REQUESTERS-1:0]            req_action,
    input  logic [ADDRESS_BITS*REQUESTERS-1:0] req_array,
    input  logic [INDEX_BITS*REQUESTERS-1:0]   req_index,
    input  logic [DATA_BITS*REQUESTERS-1:0]    req_in,
    output logic [REQUESTERS-1:0]              rsp_valid,
    output logic [DATA_BITS-1:0]               rsp_out,
    output logic [31:0]                        rsp_error,
    output logic                               heap_clock,
    output logic [7:0]                         heap_action,
    output logic [ADDRESS_BITS-1:0]            heap_array,
    output logic [INDEX_BITS-1:0]              heap_index,
    output logic [DATA_BITS-1:0]               heap_in,
    input  logic [DATA_BITS-1:0]               heap_out,
    input  logic [31:0]                        heap_error
);

    localparam int PW = $clog2(REQUESTERS);

    heap_arb_state_t state_reg, state_next;

    logic [7:0]              act_arr [REQUESTERS];
    logic [ADDRESS_BITS-1:0] arr_arr [REQUESTERS];
    logic [INDEX_BITS-1:0]   idx_arr [REQUESTERS];
    logic [DATA_BITS-1:0]    in_arr  [REQUESTERS];

    logic [REQUESTERS-1:0] pick_mask, pick_grant;
    logic                  pick_any;
    logic [PW-1:0]         win_idx;
    logic                  win_legal;
    logic                  accept;

    logic [PW-1:0]           owner_reg;
    logic [7:0]              act_reg;
    logic [ADDRESS_BITS-1:0] arr_reg;
    logic [INDEX_BITS-1:0]   idx_reg;
    logic [DATA_BITS-1:0]    in_reg;
    logic                    bad_reg;

    logic [7:0]              heap_action_reg;
    logic [ADDRESS_BITS-1:0] heap_array_reg;
    logic [INDEX_BITS-1:0]   heap_index_reg;
    logic [DATA_BITS-1:0]    heap_in_reg;
    logic                    heap_clock_reg;

    logic [REQUESTERS-1:0] rsp_valid_reg;
    logic [DATA_BITS-1:0]  rsp_out_reg;
    logic [31:0]           rsp_error_reg;

    logic [PW-1:0] rr_ptr_reg, rr_ptr_wrap;
    logic          lock_reg, lock_next;
    logic [PW-1:0] lock_owner_reg;
    logic          lock_release;

    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
            assign act_arr[gi]   = req_action[gi*8 +: 8];
            assign arr_arr[gi]   = req_array[gi*ADDRESS_BITS +: ADDRESS_BITS];
            assign idx_arr[gi]   = req_index[gi*INDEX_BITS +: INDEX_BITS];
            assign in_arr[gi]    = req_in[gi*DATA_BITS +: DATA_BITS];
            assign pick_mask[gi] = ~lock_reg | (lock_owner_reg == PW'(gi));
        end
    endgenerate

    rr_pick #(.N(REQUESTERS)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_reg),
        .mask  (pick_mask),
        .grant (pick_grant),
        .any   (pick_any)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (pick_grant[k]) begin
                win_idx = PW'(k);
            end
        end
    end

    assign win_legal = action_legal(act_arr[win_idx], lock_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Illegal requests jump straight to CAPTURE so the heap never sees a strobe.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    accept     = 1'b1;
                    state_next = win_legal ? SETUP : CAPTURE;
                end
            end
            SETUP:   state_next = STROBE;
            STROBE:  state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (accept && !reset) ? pick_grant : '0;

    assign lock_release = !bad_reg && (act_reg == ACT_LONG2) && lock_reg &&
                          (owner_reg == lock_owner_reg);
    assign lock_next    = lock_reg && !lock_release;
    assign rr_ptr_wrap  = (owner_reg == PW'(REQUESTERS-1)) ? '0 : owner_reg + PW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_reg       <= '0;
            act_reg         <= '0;
            arr_reg         <= '0;
            idx_reg         <= '0;
            in_reg          <= '0;
            bad_reg         <= 1'b0;
            heap_action_reg <= '0;
            heap_array_reg  <= '0;
            heap_index_reg  <= '0;
            heap_in_reg     <= '0;
            heap_clock_reg  <= 1'b0;
            rsp_valid_reg   <= '0;
            rsp_out_reg     <= '0;
            rsp_error_reg   <= '0;
            rr_ptr_reg      <= '0;
            lock_reg        <= 1'b0;
            lock_owner_reg  <= '0;
        end else begin
            rsp_valid_reg <= '0;
            if (accept) begin
                owner_reg <= win_idx;
                act_reg   <= act_arr[win_idx];
                arr_reg   <= arr_arr[win_idx];
                idx_reg   <= idx_arr[win_idx];
                in_reg    <= in_arr[win_idx];
                bad_reg   <= !win_legal;
                if (win_legal && (act_arr[win_idx] == ACT_LONG1)) begin
                    lock_reg       <= 1'b1;
                    lock_owner_reg <= win_idx;
                end
            end
            if (state_reg == SETUP) begin
                heap_action_reg <= act_reg;
                heap_array_reg  <= arr_reg;
                heap_index_reg  <= idx_reg;
                heap_in_reg     <= in_reg;
            end
            if (state_reg == STROBE) begin
                heap_clock_reg <= ~heap_clock_reg;
            end
            // The pointer stays put while a pair is open, so the owner keeps priority.
            if (state_reg == CAPTURE) begin
                rsp_valid_reg[owner_reg] <= 1'b1;
                rsp_out_reg              <= bad_reg ? '0 : heap_out;
                rsp_error_reg            <= bad_reg ? HEAP_ERR_BAD_ACTION : heap_error;
                lock_reg                 <= lock_next;
                if (!lock_next) begin
                    rr_ptr_reg <= rr_ptr_wrap;
                end
            end
        end
    end

    assign heap_clock  = heap_clock_reg;
    assign heap_action = heap_action_reg;
    assign heap_array  = heap_array_reg;
    assign heap_index  = heap_index_reg;
    assign heap_in     = heap_in_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_out     = rsp_out_reg;
    assign rsp_error   = rsp_error_reg;

endmodule

// File: tb/tb_heap_arbiter.sv
// Randomised scoreboard bench for heap_arbiter with a stand-in heap and a
// rule-level model of grant order, lock and timing.
module tb_heap_arbiter;

    localparam int NR = 4;
    localparam int AB = 2;
    localparam int IB = 1;
    localparam int DB = 12;
    localparam logic [7:0]  SIZE_ACT = 8'd3;
    localparam logic [31:0] ERR_BAD  = 32'h1000_0280;

    typedef struct {
        logic [7:0]    act;
        logic [AB-1:0] arr;
        logic [IB-1:0] idx;
        logic [DB-1:0] din;
    } cmd_t;

    typedef struct {
        int            id;
        logic [DB-1:0] out;
        logic [31:0]   err;
        int            exp_cyc;
        int            tog;
    } rsp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [8*NR-1:0]  req_action = '0;
    logic [AB*NR-1:0] req_array = '0;
    logic [IB*NR-1:0] req_index = '0;
    logic [DB*NR-1:0] req_in = '0;
    logic [NR-1:0]    rsp_valid;
    logic [DB-1:0]    rsp_out;
    logic [31:0]      rsp_error;
    logic             heap_clock;
    logic [7:0]       heap_action;
    logic [AB-1:0]    heap_array;
    logic [IB-1:0]    heap_index;
    logic [DB-1:0]    heap_in;
    logic [DB-1:0]    heap_out = '0;
    logic [31:0]      heap_error = '0;

    cmd_t cq[NR][$];
    rsp_t sb[$];
    int   glog[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, toggles = 0, last_tog = 0;
    int   next_ok = 0, mptr = 0, mown = 0, last_T = 0;
    bit   mlock = 1'b0;
    logic [NR-1:0] acc = '0;
    logic [DB-1:0] last_out = '0;
    logic [31:0]   last_err = '0;

    heap_arbiter #(.REQUESTERS(NR), .ADDRESS_BITS(AB), .INDEX_BITS(IB), .DATA_BITS(DB)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_action(req_action), .req_array(req_array), .req_index(req_index), .req_in(req_in),
        .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_error(rsp_error),
        .heap_clock(heap_clock), .heap_action(heap_action), .heap_array(heap_array),
        .heap_index(heap_index), .heap_in(heap_in), .heap_out(heap_out), .heap_error(heap_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DB-1:0] hfun(input cmd_t c);
        if (c.act == SIZE_ACT) return DB'(c.arr) + DB'(1);
        return c.din ^ {c.act[3:0], c.arr, c.idx, 5'b0} ^ {4'h0, c.act};
    endfunction

    function automatic logic [31:0] efun(input cmd_t c);
        return {c.act, 6'b0, c.arr, 7'b0, c.idx, c.din[7:0]};
    endfunction

    function automatic bit m_legal(input logic [7:0] a, input bit locked);
        return (a >= 8'd1) && (a <= 8'd30) && !((a == 8'd13) && !locked);
    endfunction

    function automatic cmd_t mk(input logic [7:0] a);
        cmd_t c;
        c.act = a;
        c.arr = AB'($urandom);
        c.idx = IB'($urandom);
        c.din = DB'($urandom);
        return c;
    endfunction

    function automatic logic [7:0] rnd_legal();
        logic [7:0] a;
        a = 8'($urandom_range(1, 28));
        if (a >= 8'd12) a = a + 8'd2;
        return a;
    endfunction

    // Stand-in heap: every strobe edge performs the operation currently on the bus.
    always @(heap_clock) begin
        cmd_t c;
        c.act = heap_action; c.arr = heap_array; c.idx = heap_index; c.din = heap_in;
        heap_out   <= hfun(c);
        heap_error <= efun(c);
        toggles    <= toggles + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_out", 32'(rsp_out), 32'h0);
        chk("rst_rsp_error", rsp_error, 32'h0);
        chk("rst_heap_clock", 32'(heap_clock), 32'h0);
        chk("rst_heap_bus", {heap_action, 8'(heap_array), 4'(heap_index), heap_in}, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((cq[0].size() + cq[1].size() + cq[2].size() + cq[3].size() + sb.size() > 0 ||
                acc != '0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'(n), 32'h0);
        repeat (2) @(negedge clock);
    endtask

    // Driver plus grant-order model: present queue heads, predict the next winner.
    initial begin
        logic [NR-1:0] vld;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    void'(cq[i].pop_front());
                    acc[i] = 1'b0;
                end
            end
            for (int i = 0; i < NR; i++) begin
                vld[i] = (cq[i].size() > 0);
                if (vld[i]) begin
                    req_action[i*8 +: 8]  = cq[i][0].act;
                    req_array[i*AB +: AB] = cq[i][0].arr;
                    req_index[i*IB +: IB] = cq[i][0].idx;
                    req_in[i*DB +: DB]    = cq[i][0].din;
                end
            end
            req_valid = vld;
            #1;
            begin
                int   w;
                int   t;
                bit   lg;
                cmd_t c;
                rsp_t r;
                w = -1;
                if (!reset && (cyc + 1 >= next_ok)) begin
                    for (int k = 0; k < NR; k++) begin
                        int j;
                        j = (mptr + k) % NR;
                        if (w < 0 && vld[j] && (!mlock || j == mown)) w = j;
                    end
                end
                chk("req_ready", 32'(req_ready), (w < 0) ? 32'h0 : (32'h1 << w));
                if (w >= 0) begin
                    c  = cq[w][0];
                    t  = cyc + 1;
                    lg = m_legal(c.act, mlock);
                    if (lg && c.act == 8'd12) begin mlock = 1'b1; mown = w; end
                    else if (lg && c.act == 8'd13 && w == mown) mlock = 1'b0;
                    if (!mlock) mptr = (w + 1) % NR;
                    r.id      = w;
                    r.out     = lg ? hfun(c) : '0;
                    r.err     = lg ? efun(c) : ERR_BAD;
                    r.exp_cyc = lg ? t + 3 : t + 1;
                    r.tog     = lg ? 1 : 0;
                    sb.push_back(r);
                    next_ok = lg ? t + 4 : t + 2;
                    last_T  = t;
                    acc[w]  = 1'b1;
                    glog.push_back(w);
                end
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (!reset) begin
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                    end else begin
                        rsp_t e;
                        e = sb.pop_front();
                        chk("rsp_valid", 32'(rsp_valid), 32'h1 << e.id);
                        chk("rsp_cycle", 32'(cyc), 32'(e.exp_cyc));
                        chk("rsp_out", 32'(rsp_out), 32'(e.out));
                        chk("rsp_error", rsp_error, e.err);
                        chk("heap_toggles", 32'(toggles - last_tog), 32'(e.tog));
                        last_tog = toggles;
                        last_out = rsp_out;
                        last_err = rsp_error;
                        $display("rsp r%0d out=%h err=%h cyc=%0d", e.id, rsp_out, rsp_error, cyc);
                    end
                end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
                    chk("rsp_timeout", 32'(cyc), 32'(sb[0].exp_cyc));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int n;
        int t;
        repeat (3) @(negedge clock);
        #2;
        check_reset_outputs();
        @(negedge clock);
        reset = 1'b0;
        last_tog = toggles;

        // Size on array 1 returns 2
        begin cmd_t c; c = mk(SIZE_ACT); c.arr = 2'd1; cq[0].push_back(c); end
        drain();
        chk("size_grant", 32'(glog[$]), 32'h0);
        chk("size_out", 32'(last_out), 32'h2);

        // All four valid back to back: strict rotation
        b = glog.size();
        for (int i = 0; i < NR; i++) begin
            cq[i].push_back(mk(rnd_legal()));
            cq[i].push_back(mk(rnd_legal()));
        end
        drain();
        for (int i = 1; i < 2 * NR; i++) chk("rr_order", 32'(glog[b+i]), 32'((glog[b+i-1] + 1) % NR));

        // Long1/Long2 pair from R1 holds off R2
        b = glog.size();
        cq[1].push_back(mk(8'd12));
        cq[1].push_back(mk(rnd_legal()));
        cq[1].push_back(mk(8'd13));
        repeat (2) @(negedge clock);
        cq[2].push_back(mk(rnd_legal()));
        drain();
        chk("lock_g0", 32'(glog[b]), 32'h1);
        chk("lock_g1", 32'(glog[b+1]), 32'h1);
        chk("lock_g2", 32'(glog[b+2]), 32'h1);
        chk("lock_g3", 32'(glog[b+3]), 32'h2);

        // Illegal action 31
        cq[3].push_back(mk(8'd31));
        drain();
        chk("bad_err", last_err, ERR_BAD);
        chk("bad_out", 32'(last_out), 32'h0);

        // Move the pointer away from 0, then reset during STROBE
        cq[1].push_back(mk(rnd_legal()));
        drain();
        b = glog.size();
        cq[2].push_back(mk(rnd_legal()));
        n = 0;
        while (glog.size() == b && n < 50) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk("strobe_grant_seen", 32'(glog.size() - b), 32'h1);
        t = last_T;
        n = 0;
        while (cyc != t + 1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        sb.delete();
        mlock = 1'b0;
        mptr = 0;
        next_ok = 0;
        @(negedge clock);
        #2;
        check_reset_outputs();
        @(negedge clock);
        reset = 1'b0;
        last_tog = toggles;
        b = glog.size();
        cq[1].push_back(mk(rnd_legal()));
        cq[0].push_back(mk(rnd_legal()));
        drain();
        chk("post_reset_grant", 32'(glog[b]), 32'h0);

        // Random traffic including locked pairs and illegal codes
        repeat (400) begin
            @(negedge clock);
            if ($urandom_range(0, 3) == 0) begin
                int r;
                int s;
                r = $urandom_range(0, NR - 1);
                s = $urandom_range(0, 11);
                if (cq[r].size() < 3) begin
                    case (s)
                        0: begin
                            cq[r].push_back(mk(8'd12));
                            cq[r].push_back(mk(rnd_legal()));
                            cq[r].push_back(mk(8'd13));
                        end
                        1: cq[r].push_back(mk(8'd0));
                        2: cq[r].push_back(mk(8'($urandom_range(31, 255))));
                        3: cq[r].push_back(mk(8'd13));
                        default: cq[r].push_back(mk(rnd_legal()));
                    endcase
                end
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
